// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage
//   IF stage of the IITB-RISC pipeline. Holds the word-addressed PC, presents
//   it to a combinational instruction ROM, and captures the returned word into
//   the IF/ID register. Handles hazard stall, flush and downstream redirects,
//   and counts instructions accepted into IF/ID.
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   rom_pc            word address to ROM (combinational copy of the PC)
//   rom_instr         same-cycle ROM data
//   stall             hold PC and IF/ID
//   flush             bubble IF/ID on the next edge
//   redirect_valid/pc load a new PC, bubble IF/ID
//   if_id_*           registered IF/ID slot (instr, pc, pc+1, valid)
//   fetch_count       instructions accepted into IF/ID, wraps mod 2^32
module instr_fetch_stage #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter logic [15:0] BUBBLE_INSTR = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] rom_pc,
  input  logic [15:0] rom_instr,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc,
  output logic [15:0] if_id_pc_plus1,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] pc_plus1;
    logic        valid;
  } if_id_t;

  logic [15:0] r_pc;
  if_id_t      r_slot;
  logic [31:0] r_cnt;
  logic [15:0] w_pc_inc;

  // 16-bit add wraps FFFF -> 0000 naturally
  assign w_pc_inc = r_pc + 16'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc            <= RESET_PC;
      r_slot.instr    <= BUBBLE_INSTR;
      r_slot.pc       <= '0;
      r_slot.pc_plus1 <= '0;
      r_slot.valid    <= 1'b0;
      r_cnt           <= '0;
    end else if (redirect_valid) begin
      // redirect beats stall/flush; slot pc fields are left as they were
      r_pc         <= redirect_pc;
      r_slot.instr <= BUBBLE_INSTR;
      r_slot.valid <= 1'b0;
    end else if (flush) begin
      // the word fetched this cycle is dropped; PC still advances unless stalled
      r_slot.instr <= BUBBLE_INSTR;
      r_slot.valid <= 1'b0;
      if (!stall) r_pc <= w_pc_inc;
    end else if (!stall) begin
      r_slot.instr    <= rom_instr;
      r_slot.pc       <= r_pc;
      r_slot.pc_plus1 <= w_pc_inc;
      r_slot.valid    <= 1'b1;
      r_pc            <= w_pc_inc;
      r_cnt           <= r_cnt + 32'd1;
    end
  end

  assign rom_pc         = r_pc;
  assign if_id_instr    = r_slot.instr;
  assign if_id_pc       = r_slot.pc;
  assign if_id_pc_plus1 = r_slot.pc_plus1;
  assign if_id_valid    = r_slot.valid;
  assign fetch_count    = r_cnt;

endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
IF stage of the IITB-RISC pipeline. Holds the program counter, drives the word address into the combinational instruction ROM and captures the returned 16-bit instruction into the IF/ID pipeline register. Handles stall from the hazard unit, flush, and PC redirect for branches and jumps resolved downstream. Also provides a fetched-instruction counter for performance checks.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
BUBBLE_INSTR, 16'hFFFF, value placed in if_id_instr when the slot is invalid (decode keys on if_id_valid, not on this value)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-low
rom_pc  output  16  word address to instruction ROM; combinational copy of pc_q
rom_instr  input  16  instruction word from ROM; same-cycle combinational return
stall  input  1  hold PC and IF/ID contents
flush  input  1  invalidate IF/ID on next edge
redirect_valid  input  1  load redirect_pc into PC (branch/jump taken)
redirect_pc  input  16  redirect target, word address
if_id_instr  output  16  registered instruction
if_id_pc  output  16  registered PC of if_id_instr
if_id_pc_plus1  output  16  registered PC+1, modulo 2^16, for JAL/JLR link
if_id_valid  output  1  IF/ID slot holds a real instruction
fetch_count  output  32  count of instructions accepted into IF/ID

Behaviour:
- Word-addressed. PC increments by 1 per fetch and wraps 16'hFFFF -> 16'h0000. No 2^15 bound check (ROM depth is the program's responsibility).
- rom_pc = pc_q. Zero-cycle combinational path; the ROM returns rom_instr in the same cycle.
- Reset (rst_n=0 at an edge): pc_q=RESET_PC; if_id_instr=BUBBLE_INSTR; if_id_pc=0; if_id_pc_plus1=0; if_id_valid=0; fetch_count=0. Reset overrides all other inputs, including mid-stall and mid-redirect.
- First valid instruction appears in IF/ID one edge after rst_n goes high.
- Per-edge priority when rst_n=1:
  1. redirect_valid=1: pc_q<=redirect_pc; IF/ID<=bubble (valid=0, instr=BUBBLE_INSTR, pc and pc_plus1 unchanged). Applies regardless of stall and flush.
  2. else flush=1: IF/ID<=bubble. pc_q<=pc_q+1 if stall=0, else pc_q holds.
  3. else stall=1: pc_q and all IF/ID outputs hold.
  4. else normal: if_id_instr<=rom_instr; if_id_pc<=pc_q; if_id_pc_plus1<=pc_q+1; if_id_valid<=1; pc_q<=pc_q+1.
- fetch_count increments by 1 only on case 4 edges. Wraps modulo 2^32. Never increments on bubble or hold edges.
- State summary (implicit two-state slot): EMPTY (valid=0) and FULL (valid=1).
  - EMPTY->FULL on a normal edge.
  - FULL->EMPTY on redirect or flush.
  - Stall holds the current state.
- Back-to-back redirects: each one takes effect, and the last one wins.
- Redirect to the current pc_q is legal: it refetches that address and the slot is still bubbled.
- All outputs are registered except rom_pc. No combinational path from stall, flush or redirect to any output.

Test Plan:
- Reset then release with ROM[0..3]=16'h1298,16'h129A,16'h1299,16'h129B, no stall -> rom_pc 0,1,2,3 on consecutive cycles; IF/ID shows (0,16'h1298),(1,16'h129A),... one cycle later; valid=1 from first post-reset edge; fetch_count=4 after 4 edges.
- Stall for 3 cycles while if_id_pc=2 -> rom_pc stays 3, if_id_pc/instr unchanged, fetch_count unchanged; on release the next edge captures address 3.
- redirect_valid=1, redirect_pc=16'h0045, with stall=1 the same cycle -> next edge: valid=0, pc_q=16'h0045; following edge: if_id_pc=16'h0045, valid=1.
- flush=1 alone at pc_q=7 -> valid=0 next edge, pc_q=8; flush+stall at pc_q=7 -> valid=0, pc_q stays 7.
- RESET_PC=16'hFFFF -> first fetch at 16'hFFFF with if_id_pc_plus1=16'h0000; next rom_pc=16'h0000.
- Assert rst_n=0 during a stall with pc_q=16'h0010 and fetch_count=9 -> next edge: pc_q=RESET_PC, valid=0, fetch_count=0.
